// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port arbiter sharing one external ALU, with credit-limited per-port response FIFOs
module alu_arbiter #(
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 2,
  parameter int ARB_MODE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [DATA_W-1:0] p0_req_da,
  input  logic [DATA_W-1:0] p0_req_db,
  input  logic [3:0]        p0_req_ctl,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [DATA_W-1:0] p0_rsp_dc,
  output logic              p0_rsp_zero,
  output logic              p0_rsp_ovf,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [DATA_W-1:0] p1_req_da,
  input  logic [DATA_W-1:0] p1_req_db,
  input  logic [3:0]        p1_req_ctl,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [DATA_W-1:0] p1_rsp_dc,
  output logic              p1_rsp_zero,
  output logic              p1_rsp_ovf,
  input  logic              flush0,
  output logic [DATA_W-1:0] alu_da,
  output logic [DATA_W-1:0] alu_db,
  output logic [3:0]        alu_ctl,
  input  logic [DATA_W-1:0] alu_dc,
  input  logic              alu_zero,
  input  logic              alu_ovf
);
  localparam logic [2:0] DEP = 3'(RSP_DEPTH);
  localparam logic [1:0] LST = 2'(RSP_DEPTH - 1);
  logic [1:0] req_v, rsp_r, rsp_v, elig, grant, pop, push, clr, rsp_z, rsp_o;
  logic [1:0][DATA_W-1:0] rsp_dc;
  logic iss_v_q, iss_own_q, last_q;
  logic [DATA_W-1:0] da_q, db_q;
  logic [3:0] ctl_q;
  assign req_v = {p1_req_valid, p0_req_valid};
  assign rsp_r = {p1_rsp_ready, p0_rsp_ready};
  assign clr   = {1'b0, flush0};
  // last_q resets to 1 so port 0 wins the first tie
  assign grant[0] = req_v[0] & elig[0] & (~(req_v[1] & elig[1]) | (ARB_MODE != 0) | last_q);
  assign grant[1] = req_v[1] & elig[1] & ~grant[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_v_q   <= 1'b0;
      iss_own_q <= 1'b0;
      last_q    <= 1'b1;
      da_q      <= '0;
      db_q      <= '0;
      ctl_q     <= '0;
    end else begin
      iss_v_q <= |grant;
      if (|grant) begin
        iss_own_q <= grant[1];
        last_q    <= grant[1];
        da_q      <= grant[1] ? p1_req_da : p0_req_da;
        db_q      <= grant[1] ? p1_req_db : p0_req_db;
        ctl_q     <= grant[1] ? p1_req_ctl : p0_req_ctl;
      end
    end
  end
  for (genvar g = 0; g < 2; g++) begin : g_port
    localparam logic OWN = 1'(g);
    logic [DATA_W+1:0] mem_q [4];
    logic [1:0] rd_q, wr_q;
    logic [2:0] fill_q, cnt_q;
    assign rsp_v[g] = fill_q != 3'd0;
    assign pop[g]   = rsp_v[g] & rsp_r[g];
    assign push[g]  = iss_v_q & (iss_own_q == OWN) & ~clr[g];
    assign elig[g]  = ((cnt_q < DEP) | pop[g]) & ~clr[g] & ~rst;
    assign {rsp_o[g], rsp_z[g], rsp_dc[g]} = rsp_v[g] ? mem_q[rd_q] : '0;
    // cnt_q counts in-flight plus buffered results, so the FIFO cannot overflow
    always_ff @(posedge clk) begin
      if (rst | clr[g]) begin
        rd_q   <= '0;
        wr_q   <= '0;
        fill_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[g]) begin
          mem_q[wr_q] <= {alu_ovf, alu_zero, alu_dc};
          wr_q        <= (wr_q == LST) ? 2'd0 : wr_q + 2'd1;
        end
        if (pop[g]) rd_q <= (rd_q == LST) ? 2'd0 : rd_q + 2'd1;
        fill_q <= fill_q + 3'(push[g]) - 3'(pop[g]);
        cnt_q  <= cnt_q + 3'(grant[g]) - 3'(pop[g]);
      end
    end
    a_no_ovf: assert property (@(posedge clk) disable iff (rst) !(push[g] && !pop[g] && fill_q == DEP));
  end
  assign p0_req_ready = grant[0];
  assign p1_req_ready = grant[1];
  assign p0_rsp_valid = rsp_v[0];
  assign p1_rsp_valid = rsp_v[1];
  assign p0_rsp_dc    = rsp_dc[0];
  assign p1_rsp_dc    = rsp_dc[1];
  assign p0_rsp_zero  = rsp_z[0];
  assign p1_rsp_zero  = rsp_z[1];
  assign p0_rsp_ovf   = rsp_o[0];
  assign p1_rsp_ovf   = rsp_o[1];
  assign alu_da       = da_q;
  assign alu_db       = db_q;
  assign alu_ctl      = ctl_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, backpressure, flush and reset
module tb_alu_arbiter;
  logic clk = 1'b0, rst = 1'b1, flush0 = 1'b0;
  logic p0_req_valid = 1'b0, p1_req_valid = 1'b0, p0_rsp_ready = 1'b1, p1_rsp_ready = 1'b1;
  logic [31:0] p0_req_da = '0, p0_req_db = '0, p1_req_da = '0, p1_req_db = '0;
  logic [3:0] p0_req_ctl = '0, p1_req_ctl = '0;
  logic p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_zero, p1_rsp_zero, p0_rsp_ovf, p1_rsp_ovf;
  logic [31:0] p0_rsp_dc, p1_rsp_dc, alu_da, alu_db, alu_dc;
  logic [3:0] alu_ctl;
  logic alu_zero, alu_ovf;
  logic d_p0_req_ready, d_p1_req_ready, d_p0_rsp_valid, d_p1_rsp_valid, d_p0_rsp_zero, d_p1_rsp_zero, d_p0_rsp_ovf, d_p1_rsp_ovf;
  logic [31:0] d_p0_rsp_dc, d_p1_rsp_dc, d_alu_da, d_alu_db, d_alu_dc;
  logic [3:0] d_alu_ctl;
  logic d_alu_zero, d_alu_ovf;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  // reference ALU: 0000 add, 0001 add+ovf, 0010 sub, 0011 sub+ovf, others AND
  function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    logic [31:0] r;
    logic o;
    r = (c[3:2] != 2'b00) ? (a & b) : c[1] ? a - b : a + b;
    o = c[0] & (c[3:2] == 2'b00) & (c[1] ? (a[31] != b[31]) : (a[31] == b[31])) & (r[31] != a[31]);
    return {o, r == 32'd0, r};
  endfunction
  assign {alu_ovf, alu_zero, alu_dc} = alu_f(alu_da, alu_db, alu_ctl);
  assign {d_alu_ovf, d_alu_zero, d_alu_dc} = alu_f(d_alu_da, d_alu_db, d_alu_ctl);
  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_da(p0_req_da), .p0_req_db(p0_req_db), .p0_req_ctl(p0_req_ctl),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_dc(p0_rsp_dc), .p0_rsp_zero(p0_rsp_zero), .p0_rsp_ovf(p0_rsp_ovf),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_da(p1_req_da), .p1_req_db(p1_req_db), .p1_req_ctl(p1_req_ctl),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_dc(p1_rsp_dc), .p1_rsp_zero(p1_rsp_zero), .p1_rsp_ovf(p1_rsp_ovf),
    .flush0(flush0), .alu_da(alu_da), .alu_db(alu_db), .alu_ctl(alu_ctl),
    .alu_dc(alu_dc), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
  );
  // deeper instance so the flush scenario can hold two buffered results plus one issuing
  alu_arbiter #(.RSP_DEPTH(4)) u_deep (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(d_p0_req_ready), .p0_req_da(p0_req_da), .p0_req_db(p0_req_db), .p0_req_ctl(p0_req_ctl),
    .p0_rsp_valid(d_p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_dc(d_p0_rsp_dc), .p0_rsp_zero(d_p0_rsp_zero), .p0_rsp_ovf(d_p0_rsp_ovf),
    .p1_req_valid(p1_req_valid), .p1_req_ready(d_p1_req_ready), .p1_req_da(p1_req_da), .p1_req_db(p1_req_db), .p1_req_ctl(p1_req_ctl),
    .p1_rsp_valid(d_p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_dc(d_p1_rsp_dc), .p1_rsp_zero(d_p1_rsp_zero), .p1_rsp_ovf(d_p1_rsp_ovf),
    .flush0(flush0), .alu_da(d_alu_da), .alu_db(d_alu_db), .alu_ctl(d_alu_ctl),
    .alu_dc(d_alu_dc), .alu_zero(d_alu_zero), .alu_ovf(d_alu_ovf)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    p0_req_valid = 1'b1;
    tick();
    tick();
    total++; if (p0_req_ready !== 1'b0) $display("FAIL reset_req_ready got %b exp 0", p0_req_ready); else passed++;
    total++; if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) $display("FAIL reset_rsp_valid got %b exp 00", {p0_rsp_valid, p1_rsp_valid}); else passed++;
    total++; if (p0_rsp_dc !== 32'd0) $display("FAIL reset_rsp_dc got %h exp 0", p0_rsp_dc); else passed++;
    total++; if ({alu_da, alu_db, alu_ctl} !== 68'd0) $display("FAIL reset_alu got %h/%h/%b exp 0", alu_da, alu_db, alu_ctl); else passed++;
    rst = 1'b0;
    p0_req_valid = 1'b0;
    tick();
  endtask
  task automatic test_round_robin;
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p0_req_valid = 1'b1; p0_req_da = 32'd1; p0_req_db = 32'd2; p0_req_ctl = 4'b0000;
      p1_req_valid = 1'b1; p1_req_da = 32'd7; p1_req_db = 32'd7; p1_req_ctl = 4'b0010;
      #1;
      total++; if (p0_req_ready !== (i % 2 == 0)) $display("FAIL rr_p0_ready cyc %0d got %b", i, p0_req_ready); else passed++;
      total++; if (p1_req_ready !== (i % 2 == 1)) $display("FAIL rr_p1_ready cyc %0d got %b", i, p1_req_ready); else passed++;
      total++; if (p0_rsp_valid !== (i >= 2 && i % 2 == 0)) $display("FAIL rr_p0_valid cyc %0d got %b", i, p0_rsp_valid); else passed++;
      total++; if (p1_rsp_valid !== (i >= 3 && i % 2 == 1)) $display("FAIL rr_p1_valid cyc %0d got %b", i, p1_rsp_valid); else passed++;
      if (i >= 2 && i % 2 == 0) begin
        total++; if (p0_rsp_dc !== 32'd3) $display("FAIL rr_p0_dc got %h exp 3", p0_rsp_dc); else passed++;
      end
      if (i >= 3 && i % 2 == 1) begin
        total++; if ({p1_rsp_dc, p1_rsp_zero} !== {32'd0, 1'b1}) $display("FAIL rr_p1_sub got %h z=%b exp 0 z=1", p1_rsp_dc, p1_rsp_zero); else passed++;
      end
      tick();
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    repeat (3) tick();
  endtask
  task automatic test_backpressure;
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p0_req_valid = 1'b1; p0_req_da = 32'(i); p0_req_db = 32'd0; p0_req_ctl = 4'b0000;
      p1_req_valid = 1'b1; p1_req_da = 32'(100 + i); p1_req_db = 32'd0; p1_req_ctl = 4'b0000;
      #1;
      total++; if (p1_req_ready !== (i == 1 || i == 3)) $display("FAIL bp_p1_ready cyc %0d got %b", i, p1_req_ready); else passed++;
      total++; if (p0_req_ready !== !(i == 1 || i == 3)) $display("FAIL bp_p0_ready cyc %0d got %b", i, p0_req_ready); else passed++;
      tick();
    end
    total++; if ({p1_rsp_valid, p1_rsp_dc} !== {1'b1, 32'd101}) $display("FAIL bp_stall_head got %b/%0d exp 1/101", p1_rsp_valid, p1_rsp_dc); else passed++;
    p0_req_valid = 1'b0;
    p1_req_da = 32'd200;
    p1_rsp_ready = 1'b1;
    #1;
    total++; if (p1_req_ready !== 1'b1) $display("FAIL bp_reaccept got %b exp 1", p1_req_ready); else passed++;
    total++; if (p1_rsp_dc !== 32'd101) $display("FAIL bp_pop0 got %0d exp 101", p1_rsp_dc); else passed++;
    tick();
    p1_req_valid = 1'b0;
    #1;
    total++; if ({p1_rsp_valid, p1_rsp_dc} !== {1'b1, 32'd103}) $display("FAIL bp_pop1 got %b/%0d exp 1/103", p1_rsp_valid, p1_rsp_dc); else passed++;
    tick();
    total++; if ({p1_rsp_valid, p1_rsp_dc} !== {1'b1, 32'd200}) $display("FAIL bp_pop2 got %b/%0d exp 1/200", p1_rsp_valid, p1_rsp_dc); else passed++;
    tick();
    total++; if (p1_rsp_valid !== 1'b0) $display("FAIL bp_empty got %b exp 0", p1_rsp_valid); else passed++;
  endtask
  task automatic test_add;
    p0_req_valid = 1'b1; p0_req_da = 32'd5; p0_req_db = 32'd3; p0_req_ctl = 4'b0000;
    #1;
    total++; if (p0_req_ready !== 1'b1) $display("FAIL add_ready got %b exp 1", p0_req_ready); else passed++;
    tick();
    p0_req_valid = 1'b0;
    #1;
    total++; if ({alu_da, alu_db, alu_ctl} !== {32'd5, 32'd3, 4'b0000}) $display("FAIL add_issue got %0d/%0d/%b exp 5/3/0000", alu_da, alu_db, alu_ctl); else passed++;
    total++; if (p0_rsp_valid !== 1'b0) $display("FAIL add_early got %b exp 0", p0_rsp_valid); else passed++;
    tick();
    total++; if ({p0_rsp_valid, p0_rsp_dc, p0_rsp_zero, p0_rsp_ovf} !== {1'b1, 32'd8, 2'b00}) $display("FAIL add_rsp got v=%b dc=%0d z=%b o=%b exp 1/8/0/0", p0_rsp_valid, p0_rsp_dc, p0_rsp_zero, p0_rsp_ovf); else passed++;
    tick();
    total++; if (p0_rsp_valid !== 1'b0) $display("FAIL add_popped got %b exp 0", p0_rsp_valid); else passed++;
  endtask
  task automatic test_overflow;
    for (int j = 0; j < 2; j++) begin
      p0_req_valid = 1'b1; p0_req_da = 32'h7FFF_FFFF; p0_req_db = 32'd1; p0_req_ctl = (j == 0) ? 4'b0001 : 4'b0000;
      tick();
      p0_req_valid = 1'b0;
      tick();
      total++; if ({p0_rsp_valid, p0_rsp_dc, p0_rsp_zero, p0_rsp_ovf} !== {1'b1, 32'h8000_0000, 1'b0, (j == 0)}) $display("FAIL ovf_%0d got v=%b dc=%h z=%b o=%b", j, p0_rsp_valid, p0_rsp_dc, p0_rsp_zero, p0_rsp_ovf); else passed++;
      tick();
    end
  endtask
  task automatic test_flush;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0_rsp_ready = 1'b0;
    p1_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p0_req_valid = 1'b1; p0_req_da = 32'(i + 1); p0_req_db = 32'd1; p0_req_ctl = 4'b0000;
      #1;
      if (i == 2) begin
        total++; if ({p0_req_ready, d_p0_req_ready} !== 2'b01) $display("FAIL fl_credit got %b%b exp 01", p0_req_ready, d_p0_req_ready); else passed++;
      end
      tick();
    end
    flush0 = 1'b1;
    p1_req_valid = 1'b1; p1_req_da = 32'd9; p1_req_db = 32'd4; p1_req_ctl = 4'b0010;
    #1;
    total++; if ({p0_rsp_valid, d_p0_rsp_valid} !== 2'b11) $display("FAIL fl_buffered got %b%b exp 11", p0_rsp_valid, d_p0_rsp_valid); else passed++;
    total++; if ({p0_req_ready, d_p0_req_ready, p1_req_ready, d_p1_req_ready} !== 4'b0011) $display("FAIL fl_grant got %b%b%b%b exp 0011", p0_req_ready, d_p0_req_ready, p1_req_ready, d_p1_req_ready); else passed++;
    tick();
    flush0 = 1'b0;
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    #1;
    total++; if ({p0_rsp_valid, d_p0_rsp_valid} !== 2'b00) $display("FAIL fl_cleared got %b%b exp 00", p0_rsp_valid, d_p0_rsp_valid); else passed++;
    tick();
    total++; if ({p0_rsp_valid, d_p0_rsp_valid} !== 2'b00) $display("FAIL fl_issue_dropped got %b%b exp 00", p0_rsp_valid, d_p0_rsp_valid); else passed++;
    total++; if ({p1_rsp_valid, p1_rsp_dc, d_p1_rsp_valid, d_p1_rsp_dc} !== {1'b1, 32'd5, 1'b1, 32'd5}) $display("FAIL fl_p1 got %b/%0d %b/%0d exp 1/5", p1_rsp_valid, p1_rsp_dc, d_p1_rsp_valid, d_p1_rsp_dc); else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      p0_req_valid = 1'b1; p0_req_da = 32'd4;
      #1;
      total++; if (p0_req_ready !== (i < 2)) $display("FAIL fl_cnt_reset cyc %0d got %b", i, p0_req_ready); else passed++;
      tick();
    end
    p0_req_valid = 1'b0;
    p0_rsp_ready = 1'b1;
    repeat (4) tick();
  endtask
  task automatic test_reset_mid;
    p0_rsp_ready = 1'b0;
    p1_rsp_ready = 1'b0;
    p0_req_da = 32'd9; p0_req_db = 32'd4; p0_req_ctl = 4'b0010;
    p1_req_da = 32'd9; p1_req_db = 32'd4; p1_req_ctl = 4'b0010;
    p0_req_valid = 1'b1;
    p1_req_valid = 1'b1;
    repeat (4) tick();
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    #1;
    total++; if ({p0_rsp_valid, p1_rsp_valid, alu_ctl} !== 6'b11_0010) $display("FAIL rm_before got %b%b %b exp 11 0010", p0_rsp_valid, p1_rsp_valid, alu_ctl); else passed++;
    rst = 1'b1;
    tick();
    total++; if ({p0_rsp_valid, p1_rsp_valid, alu_ctl, p1_rsp_dc} !== {2'b00, 4'b0000, 32'd0}) $display("FAIL rm_after got %b%b %b %h exp 00 0000 0", p0_rsp_valid, p1_rsp_valid, alu_ctl, p1_rsp_dc); else passed++;
    rst = 1'b0;
    p0_req_valid = 1'b1; p0_req_da = 32'd1; p0_req_db = 32'd1; p0_req_ctl = 4'b0000;
    p1_req_valid = 1'b1;
    #1;
    total++; if ({p0_req_ready, p1_req_ready} !== 2'b10) $display("FAIL rm_first_tie got %b%b exp 10", p0_req_ready, p1_req_ready); else passed++;
    tick();
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    tick();
    total++; if ({p0_rsp_valid, p0_rsp_dc, p1_rsp_valid} !== {1'b1, 32'd2, 1'b0}) $display("FAIL rm_new_op got %b/%0d p1=%b exp 1/2 p1=0", p0_rsp_valid, p0_rsp_dc, p1_rsp_valid); else passed++;
    tick();
    total++; if (p1_rsp_valid !== 1'b0) $display("FAIL rm_no_stale got %b exp 0", p1_rsp_valid); else passed++;
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_add();
    test_overflow();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
